instruction_field_pipeline: RTL

Elastic, parametrised successor to the combinational instruction field extractor. Accepts one instruction word per cycle with its thread number under a valid/ready handshake, splits it into opcode, D, A and B operands, and delivers the fields after a configurable number of register stages. Sits between instruction memory read-out and the operand/address decode stages. Optionally flags and counts instructions whose unused MSBs, above the opcode, are non-zero.

---
 rtl/instruction_field_pipeline.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instruction_field_pipeline.sv
// Elastic instruction field splitter: valid/ready chain of PIPE_DEPTH register stages.
// Optional unused-MSB flag and error counter enabled by INSTRUCTION_FIELD_UNUSED_CHECK_EN.
module instruction_field_pipeline #(
    parameter int unsigned WORD_WIDTH      = 40,
    parameter int unsigned OPCODE_WIDTH    = 4,
    parameter int unsigned D_OPERAND_WIDTH = 12,
    parameter int unsigned A_OPERAND_WIDTH = 10,
    parameter int unsigned B_OPERAND_WIDTH = 10,
    parameter int unsigned THREAD_WIDTH    = 3,
    parameter int unsigned PIPE_DEPTH      = 2,
    parameter int unsigned ERR_COUNT_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_WIDTH-1:0]      instruction,
    input  logic [THREAD_WIDTH-1:0]    in_thread,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPCODE_WIDTH-1:0]    opcode,
    output logic [D_OPERAND_WIDTH-1:0] D_operand,
    output logic [A_OPERAND_WIDTH-1:0] A_operand,
    output logic [B_OPERAND_WIDTH-1:0] B_operand,
    output logic [THREAD_WIDTH-1:0]    out_thread,
    output logic                       unused_nonzero,
    input  logic                       err_clear,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
);
    localparam int unsigned USED = OPCODE_WIDTH + D_OPERAND_WIDTH + A_OPERAND_WIDTH
                                   + B_OPERAND_WIDTH;
    localparam int unsigned PW   = THREAD_WIDTH + USED;

    if (USED > WORD_WIDTH) begin : g_bad_used
        $error("instruction_field_pipeline: field widths exceed WORD_WIDTH");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
        $error("instruction_field_pipeline: PIPE_DEPTH must be 1..4");
    end

    logic [PIPE_DEPTH-1:0] valid_q;
    logic [PW-1:0]         payload_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] ready;
    logic [PW-1:0]         in_payload;

    assign in_payload = {in_thread, instruction[USED-1:0]};

    // Stage k can move iff out_ready or some stage from k downwards is empty.
    always_comb begin
        logic full_below;
        full_below = 1'b1;
        ready      = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            full_below = full_below & valid_q[k];
            ready[k]   = out_ready | ~full_below;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                payload_q[k] <= '0;
            end
        end else begin
            if (ready[0]) begin
                valid_q[0]   <= in_valid;
                payload_q[0] <= in_payload;
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (ready[k]) begin
                    valid_q[k]   <= valid_q[k-1];
                    payload_q[k] <= payload_q[k-1];
                end
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[PIPE_DEPTH-1];
    assign {out_thread, opcode, D_operand, A_operand, B_operand} = payload_q[PIPE_DEPTH-1];

`ifdef INSTRUCTION_FIELD_UNUSED_CHECK_EN
    logic                       in_flag;
    logic                       err_inc;
    logic [PIPE_DEPTH-1:0]      flag_q;
    logic [ERR_COUNT_WIDTH-1:0] err_count_q;

    if (USED < WORD_WIDTH) begin : g_flag
        assign in_flag = |instruction[WORD_WIDTH-1:USED];
    end else begin : g_no_flag
        assign in_flag = 1'b0;
    end

    assign err_inc = in_valid & ready[0] & in_flag;

    always_ff @(posedge clock) begin
        if (reset) begin
            flag_q      <= '0;
            err_count_q <= '0;
        end else begin
            if (ready[0]) begin
                flag_q[0] <= in_flag;
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (ready[k]) begin
                    flag_q[k] <= flag_q[k-1];
                end
            end
            // A clear coinciding with a flagged acceptance leaves that acceptance counted.
            if (err_clear) begin
                err_count_q <= ERR_COUNT_WIDTH'(err_inc);
            end else if (err_inc && !(&err_count_q)) begin
                err_count_q <= err_count_q + ERR_COUNT_WIDTH'(1);
            end
        end
    end

    assign unused_nonzero = flag_q[PIPE_DEPTH-1];
    assign err_count      = err_count_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;
    if (USED < WORD_WIDTH) begin : g_unused_hi
        logic unused_hi_bits;
        assign unused_hi_bits = ^instruction[WORD_WIDTH-1:USED];
    end
    assign unused_nonzero = 1'b0;
    assign err_count      = '0;
`endif

endmodule
